moving_average_sequencer: RTL and testbench



---
 rtl/moving_average_sequencer.sv | 157 +++++++++++++++
 tb/tb_moving_average_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moving_average_sequencer.sv
// Sequencer in front of the moving-average filter: decimates the sample stream, strobes the
// filter, hides warm-up results and presents averages on a valid/ready port.
module moving_average_sequencer #(
  parameter int unsigned DATA_IN_LEN  = 10,
  parameter int unsigned FILTER_POWER = 2,
  parameter int unsigned TIMEOUT_CYC  = 16,
  parameter int unsigned DROP_W       = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [3:0]             decim,
  input  logic                   smp_valid,
  input  logic [DATA_IN_LEN-1:0] smp_data,
  output logic [DATA_IN_LEN-1:0] filt_data,
  output logic                   filt_strobe,
  input  logic                   filt_done,
  input  logic [DATA_IN_LEN-1:0] filt_result,
  output logic                   res_valid,
  output logic [DATA_IN_LEN-1:0] res_data,
  input  logic                   res_ready,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   timeout_err,
  output logic                   busy
);

  localparam int unsigned WarmCnt = 2 ** FILTER_POWER;
  localparam int unsigned WarmW   = $clog2(WarmCnt + 1);
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StCapture,
    StPresent
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_IN_LEN-1:0] filt_data_q, filt_data_d;
  logic                   filt_strobe_q, filt_strobe_d;
  logic                   res_valid_q, res_valid_d;
  logic [DATA_IN_LEN-1:0] res_data_q, res_data_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   busy_q, busy_d;
  logic [3:0]             decim_cnt_q, decim_cnt_d;
  logic [WarmW-1:0]       warm_q, warm_d;
  logic [ToW-1:0]         to_q, to_d;

  always_comb begin
    state_d       = state_q;
    filt_data_d   = filt_data_q;
    filt_strobe_d = 1'b0;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    drop_d        = drop_q;
    timeout_err_d = timeout_err_q;
    decim_cnt_d   = decim_cnt_q;
    warm_d        = warm_q;
    to_d          = to_q;

    unique case (state_q)
      StIdle: begin
        if (!enable) begin
          decim_cnt_d = '0;
        end else if (smp_valid) begin
          if (decim_cnt_q == '0) begin
            filt_data_d   = smp_data;
            decim_cnt_d   = decim;
            filt_strobe_d = 1'b1;
            state_d       = StIssue;
          end else begin
            decim_cnt_d = decim_cnt_q - 4'd1;
          end
        end
      end
      StIssue: begin
        to_d    = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        // filt_data is left untouched here; the filter re-samples it with done.
        if (filt_done) begin
          state_d = StCapture;
        end else begin
          to_d = to_q + ToW'(1);
          if (to_d == ToW'(TIMEOUT_CYC)) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
          end
        end
      end
      StCapture: begin
        if (warm_q < WarmW'(WarmCnt)) begin
          warm_d  = warm_q + WarmW'(1);
          state_d = StIdle;
        end else begin
          res_data_d  = filt_result;
          res_valid_d = 1'b1;
          state_d     = StPresent;
        end
      end
      StPresent: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Samples are only accepted in idle; anything else offered while enabled is lost.
    if (enable && smp_valid && (state_q != StIdle) && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      filt_data_q   <= '0;
      filt_strobe_q <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      drop_q        <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      decim_cnt_q   <= '0;
      warm_q        <= '0;
      to_q          <= '0;
    end else begin
      state_q       <= state_d;
      filt_data_q   <= filt_data_d;
      filt_strobe_q <= filt_strobe_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      drop_q        <= drop_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      decim_cnt_q   <= decim_cnt_d;
      warm_q        <= warm_d;
      to_q          <= to_d;
    end
  end

  assign filt_data   = filt_data_q;
  assign filt_strobe = filt_strobe_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign drop_cnt    = drop_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Bench for moving_average_sequencer: behavioural 4-tap filter plus a result scoreboard.
module tb_moving_average_sequencer;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         reset_n, enable, smp_valid, filt_strobe, filt_done, res_valid, res_ready;
  logic         timeout_err, busy;
  logic [3:0]   decim;
  logic [W-1:0] smp_data, filt_data, filt_result, res_data;
  logic [7:0]   drop_cnt;

  always #5 clk = ~clk;

  moving_average_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .decim      (decim),
    .smp_valid  (smp_valid),
    .smp_data   (smp_data),
    .filt_data  (filt_data),
    .filt_strobe(filt_strobe),
    .filt_done  (filt_done),
    .filt_result(filt_result),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .drop_cnt   (drop_cnt),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Filter model: done 2^P+1 cycles after strobe, result registered on the done edge.
  logic         stub = 1'b0;
  int           fcnt;
  logic [W-1:0] win0, win1, win2;

  always @(posedge clk) begin
    if (!reset_n) begin
      fcnt        <= 0;
      filt_done   <= 1'b0;
      filt_result <= '0;
      win0        <= '0;
      win1        <= '0;
      win2        <= '0;
    end else begin
      filt_done <= 1'b0;
      if (filt_strobe && !stub) begin
        fcnt <= 4;
      end else if (fcnt > 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1) filt_done <= 1'b1;
      end
      if (filt_done) begin
        filt_result <= W'((32'(filt_data) + 32'(win0) + 32'(win1) + 32'(win2)) >> 2);
        win0 <= filt_data;
        win1 <= win0;
        win2 <= win1;
      end
    end
  end

  // Expected results, pushed when an accepted sample is driven.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] h0, h1, h2, h3;
  int           exp_warm, exp_drop, strobe_cnt;

  task automatic note_accept(input logic [W-1:0] v);
    h3 = h2;
    h2 = h1;
    h1 = h0;
    h0 = v;
    if (exp_warm < 4) exp_warm++;
    else exp_q.push_back(W'((32'(h0) + 32'(h1) + 32'(h2) + 32'(h3)) >> 2));
  endtask

  task automatic clear_model();
    h0 = '0;
    h1 = '0;
    h2 = '0;
    h3 = '0;
    exp_warm = 0;
    exp_drop = 0;
  endtask

  initial begin
    strobe_cnt = 0;
    forever begin
      @(negedge clk);
      if (filt_strobe === 1'b1) strobe_cnt++;
      if (reset_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) check_eq("sb_unexpected_result", 0, 1);
        else check_eq("sb_res_data", res_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_filt_data"}, filt_data, 0);
    check_eq({pfx, "_filt_strobe"}, filt_strobe, 0);
    check_eq({pfx, "_res_valid"}, res_valid, 0);
    check_eq({pfx, "_res_data"}, res_data, 0);
    check_eq({pfx, "_drop_cnt"}, drop_cnt, 0);
    check_eq({pfx, "_timeout_err"}, timeout_err, 0);
    check_eq({pfx, "_busy"}, busy, 0);
  endtask

  int           busy_left, dcnt, s0;
  logic [W-1:0] exp_c;

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    decim     = 4'd0;
    smp_valid = 1'b0;
    smp_data  = '0;
    res_ready = 1'b1;
    clear_model();
    tick(3);
    check_reset("rst");
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(1);

    // Warm-up and basic latency, one sample every 12 cycles.
    for (int k = 0; k < 6; k++) begin
      smp_valid = 1'b1;
      smp_data  = W'((k + 1) * 10);
      note_accept(smp_data);
      tick(1);
      smp_valid = 1'b0;
      if (k == 0) check_eq("a_strobe_on", filt_strobe, 1);
      tick(1);
      if (k == 0) begin
        check_eq("a_strobe_off", filt_strobe, 0);
        check_eq("a_busy", busy, 1);
      end
      tick(5);
      check_eq("a_filt_data_hold", filt_data, (k + 1) * 10);
      check_eq("a_valid_early", res_valid, 0);
      tick(1);
      check_eq("a_valid_at_8", res_valid, k >= 4);
      if (k >= 4) check_eq("a_res_data", res_data, (k == 4) ? 35 : 45);
      tick(4);
    end
    check_eq("a_drop_cnt", drop_cnt, exp_drop);

    // Decimation by 3 against a continuous stream.
    decim     = 4'd2;
    busy_left = 0;
    dcnt      = 0;
    for (int i = 0; i < 40; i++) begin
      smp_valid = 1'b1;
      smp_data  = W'(i + 1);
      if (busy_left > 0) begin
        exp_drop++;
        busy_left--;
      end else if (dcnt > 0) begin
        dcnt--;
      end else begin
        note_accept(smp_data);
        dcnt      = 2;
        busy_left = 8;
      end
      tick(1);
      check_eq("b_busy", busy, busy_left > 0);
    end
    smp_valid = 1'b0;
    tick(12);
    check_eq("b_drop_cnt", drop_cnt, exp_drop);

    // Disabled: samples ignored, not counted, decim counter cleared.
    s0        = strobe_cnt;
    enable    = 1'b0;
    smp_valid = 1'b1;
    tick(5);
    smp_valid = 1'b0;
    enable    = 1'b1;
    decim     = 4'd0;
    tick(1);
    check_eq("dis_strobe", strobe_cnt - s0, 0);
    check_eq("dis_drop_cnt", drop_cnt, exp_drop);

    // Back-pressure in PRESENT with a streaming source.
    res_ready = 1'b0;
    smp_valid = 1'b1;
    smp_data  = W'(777);
    note_accept(smp_data);
    exp_c = W'((32'(h0) + 32'(h1) + 32'(h2) + 32'(h3)) >> 2);
    tick(1);
    smp_valid = 1'b0;
    tick(7);
    for (int j = 0; j < 20; j++) begin
      smp_valid = 1'b1;
      smp_data  = W'(j);
      check_eq("c_valid_hold", res_valid, 1);
      check_eq("c_data_hold", res_data, exp_c);
      tick(1);
    end
    smp_valid = 1'b0;
    res_ready = 1'b1;
    exp_drop += 20;
    check_eq("c_valid_before_release", res_valid, 1);
    tick(1);
    check_eq("c_valid_after_release", res_valid, 0);
    check_eq("c_busy_after_release", busy, 0);
    check_eq("c_drop_cnt", drop_cnt, exp_drop);

    // Filter never answers: timeout, then normal acceptance.
    stub      = 1'b1;
    smp_valid = 1'b1;
    smp_data  = W'(5);
    tick(1);
    smp_valid = 1'b0;
    tick(16);
    check_eq("d_no_err_yet", timeout_err, 0);
    check_eq("d_busy_waiting", busy, 1);
    tick(1);
    check_eq("d_timeout_err", timeout_err, 1);
    check_eq("d_idle", busy, 0);
    stub      = 1'b0;
    smp_valid = 1'b1;
    smp_data  = W'(9);
    note_accept(smp_data);
    tick(1);
    smp_valid = 1'b0;
    check_eq("d_next_strobe", filt_strobe, 1);
    tick(12);
    check_eq("d_err_sticky", timeout_err, 1);

    // Reset during WAIT_DONE abandons the transaction and restarts warm-up.
    smp_valid = 1'b1;
    smp_data  = W'(11);
    tick(1);
    smp_valid = 1'b0;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reset("mid_rst");
    clear_model();
    for (int k = 0; k < 5; k++) begin
      smp_valid = 1'b1;
      smp_data  = W'((k + 1) * 100);
      note_accept(smp_data);
      tick(1);
      smp_valid = 1'b0;
      tick(7);
      check_eq("e_warm_valid", res_valid, k == 4);
      if (k == 4) check_eq("e_res_data", res_data, 350);
      tick(4);
    end

    // enable falls right after acceptance: transaction completes, nothing else starts.
    s0        = strobe_cnt;
    smp_valid = 1'b1;
    smp_data  = W'(600);
    note_accept(smp_data);
    tick(1);
    enable = 1'b0;
    for (int j = 0; j < 20; j++) begin
      smp_valid = 1'b1;
      smp_data  = W'(j + 50);
      tick(1);
    end
    smp_valid = 1'b0;
    enable    = 1'b1;
    tick(1);
    check_eq("f_one_strobe", strobe_cnt - s0, 1);
    check_eq("f_drop_cnt", drop_cnt, exp_drop);
    check_eq("f_idle", busy, 0);

    tick(2);
    check_eq("sb_all_results_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
